// File: rtl/car_pkg.sv
// Shared types and defaults for the semi-auto car turn path.
package car_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_L = 2'd0,
    KIND_R = 2'd1,
    KIND_B = 2'd2
  } turn_kind_t;

  localparam logic [1:0] HEAD_N = 2'd0;
  localparam logic [1:0] HEAD_E = 2'd1;
  localparam logic [1:0] HEAD_S = 2'd2;
  localparam logic [1:0] HEAD_W = 2'd3;

  localparam int unsigned DEF_TURN_CYCLES   = 450;
  localparam int unsigned DEF_SETTLE_CYCLES = 25;

endpackage

// File: rtl/turn_executor_if.sv
// Command-stage <-> turn executor signal bundle.
interface turn_executor_if;
  logic       enable;
  logic       trigger_turn_left;
  logic       trigger_turn_right;
  logic       trigger_turn_back;
  logic       move_forward_req;
  logic       turn_left;
  logic       turn_right;
  logic       move_forward;
  logic       is_turning;
  logic [1:0] heading;

  modport master (
    output enable, trigger_turn_left, trigger_turn_right, trigger_turn_back,
           move_forward_req,
    input  turn_left, turn_right, move_forward, is_turning, heading
  );

  modport slave (
    input  enable, trigger_turn_left, trigger_turn_right, trigger_turn_back,
           move_forward_req,
    output turn_left, turn_right, move_forward, is_turning, heading
  );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise is high while trigger is high and
// was low on the previous clock.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  output logic rise
);

  logic prev;

  // Remember last cycle's trigger level, every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= trigger;
  end

  assign rise = trigger & ~prev;

endmodule

// File: rtl/turn_executor.sv
// Converts trigger edges into timed turn windows, tracks heading and gates
// forward motion while a turn or its settle period is in progress.
module turn_executor
  import car_pkg::*;
#(
  parameter  int unsigned TURN_CYCLES   = DEF_TURN_CYCLES,
  parameter  int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int unsigned CNT_W         = $clog2(2*TURN_CYCLES+1)
) (
  input logic            clk,
  input logic            rst_n,
  turn_executor_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_SINGLE = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_BACK   = CNT_W'(2*TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_CYCLES - 1);

  logic             rise_l, rise_r, rise_b, any_rise;
  state_t           state;
  turn_kind_t       kind;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] turn_last;
  logic             turn_left_q, turn_right_q, move_fwd_q, is_turning_q;
  logic [1:0]       heading_q;

  rise_detect u_rise_left  (.clk(clk), .rst_n(rst_n), .trigger(bus.trigger_turn_left),  .rise(rise_l));
  rise_detect u_rise_right (.clk(clk), .rst_n(rst_n), .trigger(bus.trigger_turn_right), .rise(rise_r));
  rise_detect u_rise_back  (.clk(clk), .rst_n(rst_n), .trigger(bus.trigger_turn_back),  .rise(rise_b));

  assign any_rise  = rise_l | rise_r | rise_b;
  assign turn_last = (kind == KIND_B) ? LAST_BACK : LAST_SINGLE;

  // Turn FSM, shared cycle counter, heading and forward gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      kind         <= KIND_L;
      cnt          <= '0;
      turn_left_q  <= 1'b0;
      turn_right_q <= 1'b0;
      move_fwd_q   <= 1'b0;
      is_turning_q <= 1'b0;
      heading_q    <= HEAD_N;
    end else if (!bus.enable) begin
      // Abort without touching heading: an unfinished turn never counts.
      state        <= IDLE;
      cnt          <= '0;
      turn_left_q  <= 1'b0;
      turn_right_q <= 1'b0;
      move_fwd_q   <= 1'b0;
      is_turning_q <= 1'b0;
    end else begin
      move_fwd_q <= bus.move_forward_req & (state == IDLE) & ~any_rise;
      case (state)
        IDLE: begin
          if (any_rise) begin
            state        <= TURN;
            cnt          <= '0;
            is_turning_q <= 1'b1;
            if (rise_b) begin
              kind         <= KIND_B;
              turn_right_q <= 1'b1;
            end else if (rise_l) begin
              kind        <= KIND_L;
              turn_left_q <= 1'b1;
            end else begin
              kind         <= KIND_R;
              turn_right_q <= 1'b1;
            end
          end
        end
        TURN: begin
          if (cnt == turn_last) begin
            state        <= SETTLE;
            cnt          <= '0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
            case (kind)
              KIND_L:  heading_q <= heading_q - 2'd1;
              KIND_R:  heading_q <= heading_q + 2'd1;
              default: heading_q <= heading_q + 2'd2;
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == LAST_SETTLE) begin
            state        <= IDLE;
            cnt          <= '0;
            is_turning_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Both actuation lines high at once would steer the car two ways.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(turn_left_q && turn_right_q));
  end

  assign bus.turn_left    = turn_left_q;
  assign bus.turn_right   = turn_right_q;
  assign bus.move_forward = move_fwd_q;
  assign bus.is_turning   = is_turning_q;
  assign bus.heading      = heading_q;

endmodule

// File: tb/tb_turn_executor.sv
// Self-checking bench for turn_executor with a time-since-trigger reference model.
module tb_turn_executor;

  localparam int TC = 4;
  localparam int SC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  turn_executor_if bus ();

  turn_executor #(.TURN_CYCLES(TC), .SETTLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: a turn is described by its start cycle and kind
  // (0=left, 1=right, 2=back); outputs follow from elapsed time.
  int         m_cyc = 0;
  int         m_start = 0;
  int         m_kind = 0;
  bit         m_busy = 0;
  logic       m_tl = 0, m_tr = 0, m_mf = 0, m_it = 0;
  logic [1:0] m_head = 0;
  logic       p_l = 0, p_r = 0, p_b = 0;

  logic       rl = 0, rr = 0, rb = 0, ren = 1, rreq = 0;

  function automatic logic [7:0] dut_vec();
    return {2'b00, bus.turn_left, bus.turn_right, bus.move_forward,
            bus.is_turning, bus.heading};
  endfunction

  function automatic logic [7:0] model_vec();
    return {2'b00, m_tl, m_tr, m_mf, m_it, m_head};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_tl = 0; m_tr = 0; m_mf = 0; m_it = 0;
    m_head = 0;
    p_l = 0; p_r = 0; p_b = 0;
  endtask

  task automatic model_edge(input logic en, input logic l, input logic r,
                            input logic b, input logic req);
    logic ul, ur, ub;
    int   e, dur;
    ul = l & ~p_l;
    ur = r & ~p_r;
    ub = b & ~p_b;
    p_l = l; p_r = r; p_b = b;
    m_cyc++;
    if (!en) begin
      m_busy = 0;
      m_tl = 0; m_tr = 0; m_it = 0; m_mf = 0;
    end else if (m_busy) begin
      e   = m_cyc - m_start;
      dur = (m_kind == 2) ? 2*TC : TC;
      if (e == dur)
        m_head = m_head + ((m_kind == 0) ? 2'd3 : (m_kind == 1) ? 2'd1 : 2'd2);
      m_tl = (m_kind == 0) && (e < dur);
      m_tr = (m_kind != 0) && (e < dur);
      m_it = (e < dur + SC);
      if (e >= dur + SC) m_busy = 0;
      m_mf = 0;
    end else if (ul | ur | ub) begin
      m_busy  = 1;
      m_start = m_cyc;
      m_kind  = ub ? 2 : (ul ? 0 : 1);
      m_tl = (m_kind == 0);
      m_tr = (m_kind != 0);
      m_it = 1;
      m_mf = 0;
    end else begin
      m_tl = 0; m_tr = 0; m_it = 0;
      m_mf = req;
    end
  endtask

  task automatic step(input logic en, input logic l, input logic r,
                      input logic b, input logic req);
    bus.enable             = en;
    bus.trigger_turn_left  = l;
    bus.trigger_turn_right = r;
    bus.trigger_turn_back  = b;
    bus.move_forward_req   = req;
    @(posedge clk);
    model_edge(en, l, r, b, req);
    #1;
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic idle_steps(input int n, input logic req);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, req);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_vec(), 8'h00);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.enable             = 1'b0;
    bus.trigger_turn_left  = 1'b0;
    bus.trigger_turn_right = 1'b0;
    bus.trigger_turn_back  = 1'b0;
    bus.move_forward_req   = 1'b0;
    #2;
    check("reset_state", dut_vec(), 8'h00);
    #1;
    rst_n = 1'b1;

    // Left turn from heading N: held trigger, one window.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("left_heading", {6'd0, bus.heading}, 8'd3);

    // Back turn from W.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("back_heading", {6'd0, bus.heading}, 8'd1);

    // Simultaneous left/right/back rises: only back runs.
    idle_steps(2, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("prio_heading", {6'd0, bus.heading}, 8'd3);

    // Right held for 20 cycles: exactly one turn.
    idle_steps(1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("held_heading", {6'd0, bus.heading}, 8'd0);

    // Fresh right edge, then a right edge during settle that must be ignored.
    idle_steps(1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("settle_edge_ignored", {6'd0, bus.heading}, 8'd1);
    idle_steps(1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("new_edge_turns", {6'd0, bus.heading}, 8'd2);

    // Forward gating around a left turn.
    idle_steps(5, 1'b1);
    check("fwd_before_turn", {7'd0, bus.move_forward}, 8'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_steps(2, 1'b1);

    // Enable dropped mid-turn: abort, heading kept at E.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_outputs", dut_vec(), 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_steps(2, 1'b0);

    // Reset pulse mid-turn.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_reset();
    idle_steps(3, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      ren  = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 5) == 0) rl = ~rl;
      if ($urandom_range(0, 5) == 0) rr = ~rr;
      if ($urandom_range(0, 7) == 0) rb = ~rb;
      rreq = 1'($urandom_range(0, 1));
      step(ren, rl, rr, rb, rreq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
